anim_sequencer: RTL and testbench

Parametrised animation frame sequencer for the VGA sprite pipeline. Counts start-of-frame ticks from the timing generator, divides them by a per-mode rate, and produces the sprite frame index that selects among the frame LUT outputs. Generalises the fixed four-frame, hardwired-rate selector to N frames, parameterised rates, pause/single-step, and optional ping-pong playback. Also exports a free-running tick counter for the background and sound generators.

---
 rtl/anim_pkg.sv | 26 ++
 rtl/rate_divider.sv | 59 +++++
 rtl/anim_sequencer.sv | 178 +++++++++++++++++
 tb/tb_anim_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/anim_pkg.sv
// anim_pkg: shared types and constants for the animation frame sequencer.
//   speed_mode_e : 2-bit playback speed select (stop / slow / fast / default)
//   ST_*         : sequencer FSM state encodings
//   DEF_*        : default parameter values for the sequencer and rate divider
package anim_pkg;

  typedef enum logic [1:0] {
    SPD_STOP    = 2'b00,
    SPD_SLOW    = 2'b01,
    SPD_FAST    = 2'b10,
    SPD_DEFAULT = 2'b11
  } speed_mode_e;

  // Sequencer states, kept as plain constants for compatibility with older tools.
  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_RUN_FWD = 2'd1;
  localparam logic [1:0] ST_RUN_REV = 2'd2;

  localparam int unsigned DEF_NUM_FRAMES  = 4;
  localparam int unsigned DEF_CNT_W       = 7;
  localparam int unsigned DEF_DIV_W       = 7;
  localparam int unsigned DEF_SLOW_DIV    = 4;
  localparam int unsigned DEF_FAST_DIV    = 2;
  localparam int unsigned DEF_DEFAULT_DIV = 64;

endpackage

// File: rtl/rate_divider.sv
// rate_divider: divides start-of-frame ticks by the rate chosen by the speed mode.
//   i_clk        : clock
//   i_rst_n      : synchronous active-low reset
//   i_tick       : start-of-frame pulse
//   i_run        : sequencer is playing (divider counts only while set)
//   i_speed_mode : 01 slow, 10 fast, 11 default (00 never counts, i_run is low)
//   o_adv_req    : combinational request to advance the frame on this tick
module rate_divider
  import anim_pkg::*;
#(
  parameter int unsigned DIV_W       = DEF_DIV_W,
  parameter int unsigned SLOW_DIV    = DEF_SLOW_DIV,
  parameter int unsigned FAST_DIV    = DEF_FAST_DIV,
  parameter int unsigned DEFAULT_DIV = DEF_DEFAULT_DIV
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tick,
  input  logic       i_run,
  input  logic [1:0] i_speed_mode,
  output logic       o_adv_req
);

  localparam logic [DIV_W-1:0] LP_ONE = DIV_W'(1);

  logic [DIV_W-1:0] r_div_cnt;
  logic [DIV_W-1:0] w_div_cnt_d;
  logic [DIV_W-1:0] w_sel_div;
  logic             w_hit;

  always_comb begin
    case (i_speed_mode)
      SPD_SLOW: w_sel_div = DIV_W'(SLOW_DIV);
      SPD_FAST: w_sel_div = DIV_W'(FAST_DIV);
      default:  w_sel_div = DIV_W'(DEFAULT_DIV);
    endcase
  end

  // >= rather than == so that dropping to a faster rate mid-count fires on
  // the very next tick instead of wrapping the counter.
  assign w_hit     = (r_div_cnt >= (w_sel_div - LP_ONE));
  assign o_adv_req = i_run & i_tick & w_hit;

  always_comb begin
    w_div_cnt_d = r_div_cnt;
    if (i_run && i_tick) begin
      w_div_cnt_d = w_hit ? '0 : (r_div_cnt + LP_ONE);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= w_div_cnt_d;
    end
  end

endmodule

// File: rtl/anim_sequencer.sv
// anim_sequencer: sprite animation frame sequencer for the VGA sprite pipeline.
//   clk           : system/pixel clock
//   rst_n         : synchronous active-low reset
//   frame_tick    : one-cycle start-of-frame pulse
//   speed_mode    : 00 stop, 01 slow, 10 fast, 11 default
//   pause         : level, holds the current frame
//   step          : one-cycle pulse, advances one frame while held
//   pingpong      : level, bounce playback (only with ANIM_PINGPONG_EN)
//   frame_num     : current frame index
//   frame_counter : free-running count of frame_tick pulses
//   advance       : one-cycle pulse in the cycle frame_num changes
//   cycle_done    : one-cycle pulse on arrival at frame 0
// Build option: define ANIM_PINGPONG_EN to enable reverse/bounce playback.
module anim_sequencer
  import anim_pkg::*;
#(
  parameter int unsigned NUM_FRAMES  = DEF_NUM_FRAMES,
  parameter int unsigned FRAME_W     = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned DIV_W       = DEF_DIV_W,
  parameter int unsigned SLOW_DIV    = DEF_SLOW_DIV,
  parameter int unsigned FAST_DIV    = DEF_FAST_DIV,
  parameter int unsigned DEFAULT_DIV = DEF_DEFAULT_DIV
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic [1:0]         speed_mode,
  input  logic               pause,
  input  logic               step,
  input  logic               pingpong,
  output logic [FRAME_W-1:0] frame_num,
  output logic [CNT_W-1:0]   frame_counter,
  output logic               advance,
  output logic               cycle_done
);

  localparam logic [FRAME_W-1:0] LP_LAST = FRAME_W'(NUM_FRAMES - 1);
  localparam logic [FRAME_W-1:0] LP_ONE  = FRAME_W'(1);

  logic [1:0]         r_state;
  logic [FRAME_W-1:0] r_frame;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_adv;
  logic               r_done;

  logic               w_run;
  logic               w_div_adv;
  logic               w_adv;
  logic [FRAME_W-1:0] w_frame_d;
  logic               w_done_d;
  logic [1:0]         w_state_d;

  // Pause/stop take effect on the same cycle they are sampled, so the rules
  // applied to a coincident tick follow the inputs rather than r_state.
  assign w_run = (speed_mode != SPD_STOP) & ~pause;

  rate_divider #(
    .DIV_W       (DIV_W),
    .SLOW_DIV    (SLOW_DIV),
    .FAST_DIV    (FAST_DIV),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_rate_divider (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_tick       (frame_tick),
    .i_run        (w_run),
    .i_speed_mode (speed_mode),
    .o_adv_req    (w_div_adv)
  );

  // Running: advance at the divided rate. Holding: step advances once.
  assign w_adv = w_run ? w_div_adv : step;

`ifdef ANIM_PINGPONG_EN
  localparam logic [FRAME_W-1:0] LP_PENULT = FRAME_W'((NUM_FRAMES > 1) ? NUM_FRAMES - 2 : 0);

  logic r_dir_rev;
  logic w_cur_rev;
  logic w_rev_d;

  // HOLD keeps the direction in r_dir_rev so playback resumes the same way.
  assign w_cur_rev = (r_state == ST_RUN_REV) | ((r_state == ST_HOLD) & r_dir_rev);
`endif

  always_comb begin
    w_frame_d = r_frame;
    w_done_d  = 1'b0;
`ifdef ANIM_PINGPONG_EN
    w_rev_d   = w_cur_rev;
`endif
    if (w_adv) begin
      if (NUM_FRAMES == 1) begin
        w_done_d = 1'b1;
      end
`ifdef ANIM_PINGPONG_EN
      else if (w_cur_rev && pingpong) begin
        if (r_frame == '0) begin
          w_frame_d = LP_ONE;
          w_rev_d   = 1'b0;
        end else begin
          w_frame_d = r_frame - LP_ONE;
          w_done_d  = (r_frame == LP_ONE);
        end
      end
`endif
      else begin
        // Forward; also covers reverse playback with pingpong dropped.
`ifdef ANIM_PINGPONG_EN
        w_rev_d = 1'b0;
`endif
        if (r_frame == LP_LAST) begin
          w_frame_d = '0;
          w_done_d  = 1'b1;
`ifdef ANIM_PINGPONG_EN
          if (pingpong) begin
            w_frame_d = LP_PENULT;
            w_done_d  = (LP_PENULT == '0);
            w_rev_d   = 1'b1;
          end
`endif
        end else begin
          w_frame_d = r_frame + LP_ONE;
        end
      end
    end
  end

  always_comb begin
    if (!w_run) begin
      w_state_d = ST_HOLD;
    end else begin
`ifdef ANIM_PINGPONG_EN
      w_state_d = w_rev_d ? ST_RUN_REV : ST_RUN_FWD;
`else
      w_state_d = ST_RUN_FWD;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= (speed_mode == SPD_STOP) ? ST_HOLD : ST_RUN_FWD;
      r_frame <= '0;
      r_cnt   <= '0;
      r_adv   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (frame_tick) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_state <= w_state_d;
      r_frame <= w_frame_d;
      r_adv   <= w_adv;
      r_done  <= w_done_d;
    end
  end

`ifdef ANIM_PINGPONG_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dir_rev <= 1'b0;
    end else begin
      r_dir_rev <= w_rev_d;
    end
  end
`else
  // Loop-only build: direction never matters, state is kept for debug visibility.
  logic [2:0] w_unused_loop;
  assign w_unused_loop = {pingpong, r_state};
`endif

  assign frame_num     = r_frame;
  assign frame_counter = r_cnt;
  assign advance       = r_adv;
  assign cycle_done    = r_done;

endmodule

// File: tb/tb_anim_sequencer.sv
// Testbench for anim_sequencer: directed stimulus, a tick/position-based model
// checked every cycle, plus literal expectations at key points. A second
// instance with NUM_FRAMES=1 runs on the same stimulus.
module tb_anim_sequencer;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic [1:0] speed_mode;
  logic       pause;
  logic       step;
  logic       pingpong;

  logic [1:0] frame_num;
  logic [6:0] frame_counter;
  logic       advance;
  logic       cycle_done;

  logic [0:0] f1_num;
  logic [6:0] f1_counter;
  logic       f1_adv;
  logic       f1_done;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state
  int m_pos;
  int m_acc;
  int e_frame;
  int e_cnt;
  int e_adv;
  int e_done;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  anim_sequencer u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_tick    (frame_tick),
    .speed_mode    (speed_mode),
    .pause         (pause),
    .step          (step),
    .pingpong      (pingpong),
    .frame_num     (frame_num),
    .frame_counter (frame_counter),
    .advance       (advance),
    .cycle_done    (cycle_done)
  );

  anim_sequencer #(
    .NUM_FRAMES (1)
  ) u_dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_tick    (frame_tick),
    .speed_mode    (speed_mode),
    .pause         (pause),
    .step          (step),
    .pingpong      (pingpong),
    .frame_num     (f1_num),
    .frame_counter (f1_counter),
    .advance       (f1_adv),
    .cycle_done    (f1_done)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int div_of(input logic [1:0] s);
    case (s)
      2'b01:   return 4;
      2'b10:   return 2;
      default: return 64;
    endcase
  endfunction

  // Frame shown after 'pos' advances: loop is pos mod N; bounce walks a
  // triangle of period 2N-2 (0,1,..,N-1,..,1).
  function automatic int frame_of(input int pos, input bit pp);
    int p;
    int q;
    if (pp && N > 1) begin
      p = 2 * N - 2;
      q = pos % p;
      return (q < N) ? q : p - q;
    end
    return pos % N;
  endfunction

  always @(posedge clk) begin : model
    bit run;
    bit adv;
    bit pp;
`ifdef ANIM_PINGPONG_EN
    pp = pingpong;
`else
    pp = 1'b0;
`endif
    if (!rst_n) begin
      m_pos   = 0;
      m_acc   = 0;
      e_cnt   = 0;
      e_frame = 0;
      e_adv   = 0;
      e_done  = 0;
    end else begin
      run = (speed_mode != 2'b00) && !pause;
      adv = 1'b0;
      if (frame_tick) e_cnt = (e_cnt + 1) % 128;
      if (run) begin
        if (frame_tick) begin
          m_acc++;
          if (m_acc >= div_of(speed_mode)) begin
            adv   = 1'b1;
            m_acc = 0;
          end
        end
      end else if (step) begin
        adv = 1'b1;
      end
      if (adv) m_pos++;
      e_frame = frame_of(m_pos, pp);
      e_adv   = int'(adv);
      e_done  = int'(adv && e_frame == 0);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("frame_num",        int'(frame_num),     e_frame);
      chk("frame_counter",    int'(frame_counter), e_cnt);
      chk("advance",          int'(advance),       e_adv);
      chk("cycle_done",       int'(cycle_done),    e_done);
      chk("n1_frame_num",     int'(f1_num),        0);
      chk("n1_frame_counter", int'(f1_counter),    e_cnt);
      chk("n1_advance",       int'(f1_adv),        e_adv);
      chk("n1_cycle_done",    int'(f1_done),       e_adv);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
    end
  endtask

  task automatic step_pulse(input bit with_tick);
    @(negedge clk);
    step       = 1'b1;
    frame_tick = with_tick;
    @(negedge clk);
    step       = 1'b0;
    frame_tick = 1'b0;
  endtask

  initial begin
    int exp_loop[8] = '{0, 1, 1, 2, 2, 3, 3, 0};
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    speed_mode = 2'b11;
    pause      = 1'b0;
    step       = 1'b0;
    pingpong   = 1'b0;

    do_reset();
    chk_en = 1'b1;
    chk("rst_frame_num", int'(frame_num), 0);
    chk("rst_counter",   int'(frame_counter), 0);
    chk("rst_advance",   int'(advance), 0);
    chk("rst_done",      int'(cycle_done), 0);

    // Default rate: one advance every 64 ticks, counter wraps at 128
    tick_n(63);
    chk("def_t63_frame", int'(frame_num), 0);
    tick_n(1);
    chk("def_t64_frame", int'(frame_num), 1);
    chk("def_t64_adv",   int'(advance), 1);
    chk("def_t64_cnt",   int'(frame_counter), 64);
    tick_n(63);
    chk("def_t127_cnt",  int'(frame_counter), 127);
    tick_n(1);
    chk("def_t128_cnt",  int'(frame_counter), 0);
    chk("def_t128_frame", int'(frame_num), 2);
    tick_n(2);
    chk("def_t130_cnt",  int'(frame_counter), 2);

    // Fast loop 0,1,2,3,0
    speed_mode = 2'b10;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      tick_n(1);
      chk("fast_frame", int'(frame_num), exp_loop[k]);
      chk("fast_done", int'(cycle_done), (k == 7) ? 1 : 0);
    end

    // Stopped: steps advance, one coincident with a tick
    speed_mode = 2'b00;
    do_reset();
    step_pulse(1'b0);
    step_pulse(1'b1);
    step_pulse(1'b0);
    chk("step_frame", int'(frame_num), 3);
    chk("step_cnt",   int'(frame_counter), 1);
    tick_n(2);
    chk("stop_tick_frame", int'(frame_num), 3);
    chk("stop_tick_cnt",   int'(frame_counter), 3);

    // Default at div 40, drop to slow: advance next tick then every 4
    speed_mode = 2'b11;
    do_reset();
    tick_n(40);
    chk("rate_t40_frame", int'(frame_num), 0);
    speed_mode = 2'b01;
    tick_n(1);
    chk("rate_sw_frame", int'(frame_num), 1);
    chk("rate_sw_adv",   int'(advance), 1);
    tick_n(3);
    chk("rate_3_frame",  int'(frame_num), 1);
    tick_n(1);
    chk("rate_4_frame",  int'(frame_num), 2);
    chk("rate_4_adv",    int'(advance), 1);

    // Pause holds, step while paused advances, step while running ignored
    speed_mode = 2'b10;
    pause      = 1'b1;
    tick_n(3);
    chk("pause_frame", int'(frame_num), 2);
    step_pulse(1'b0);
    chk("pause_step_frame", int'(frame_num), 3);
    pause = 1'b0;
    step_pulse(1'b0);
    chk("run_step_frame", int'(frame_num), 3);
    tick_n(2);
    chk("resume_frame", int'(frame_num), 0);
    chk("resume_done",  int'(cycle_done), 1);

    // Reset mid-run at frame 2 overrides a coincident tick
    do_reset();
    tick_n(4);
    chk("pre_rst_frame", int'(frame_num), 2);
    @(negedge clk);
    rst_n      = 1'b0;
    frame_tick = 1'b1;
    @(negedge clk);
    rst_n      = 1'b1;
    frame_tick = 1'b0;
    chk("mid_rst_frame", int'(frame_num), 0);
    chk("mid_rst_cnt",   int'(frame_counter), 0);
    chk("mid_rst_adv",   int'(advance), 0);
    chk("mid_rst_done",  int'(cycle_done), 0);
    tick_n(2);
    chk("n1_frame", int'(f1_num), 0);
    chk("n1_adv",   int'(f1_adv), 1);
    chk("n1_done",  int'(f1_done), 1);

`ifdef ANIM_PINGPONG_EN
    begin
      int exp_pp[12] = '{0, 1, 1, 2, 2, 3, 3, 2, 2, 1, 1, 0};
      pingpong = 1'b1;
      do_reset();
      for (int k = 0; k < 12; k++) begin
        tick_n(1);
        chk("pp_frame", int'(frame_num), exp_pp[k]);
        chk("pp_done", int'(cycle_done), (k == 11) ? 1 : 0);
      end
      pingpong = 1'b0;
      do_reset();
    end
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
